// File: rtl/main_mem_pkg.sv
// Shared types and constants for the main-memory responder.
package main_mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WB   = 2'd1,
        RD   = 2'd2
    } state_t;

    localparam int MAIN_MEM_MAX_LATENCY = 15;
    localparam int CNT_W                = 4;

endpackage

// File: rtl/main_mem_array.sv
// Single-port word RAM: synchronous write, registered read that holds until the next read.
module main_mem_array
    import main_mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    localparam int AW         = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          we,
    input  logic          re,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH_WORDS];

    // NOTE: storage has no reset branch; clearing a RAM is neither needed nor mappable to block memory.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/main_mem_responder.sv
// Memory end of the data cache miss/writeback exchange: optional writeback then optional refill read.
// Define MAIN_MEM_STATS_EN to add the rd_count / wr_count statistics outputs.
module main_mem_responder
    import main_mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wb,
    input  logic        req_rd,
    input  logic [31:0] wb_addr,
    input  logic [31:0] wb_data,
    input  logic [31:0] rd_addr,
    output logic        resp_valid,
    output logic [31:0] resp_rdata
`ifdef MAIN_MEM_STATS_EN
    ,
    output logic [31:0] rd_count,
    output logic [31:0] wr_count
`endif
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic               null_pend;
    logic               rd_q;
    logic [AW-1:0]      wb_addr_q;
    logic [AW-1:0]      rd_addr_q;
    logic [31:0]        wb_data_q;
    logic               we;
    logic               re;
    logic [AW-1:0]      mem_addr;
    logic               unused_addr_bits;

    // Addresses wrap modulo the depth, so the upper bits are deliberately dropped.
    assign unused_addr_bits = ^{wb_addr[31:AW], rd_addr[31:AW]};

    assign we       = (state == WB) && (cnt == '0);
    assign re       = (state == RD) && (cnt == '0);
    assign mem_addr = (state == WB) ? wb_addr_q : rd_addr_q;

    main_mem_array #(.DEPTH_WORDS(DEPTH_WORDS)) u_array (
        .clk   (clk),
        .reset (reset),
        .we    (we),
        .re    (re),
        .addr  (mem_addr),
        .wdata (wb_data_q),
        .rdata (resp_rdata)
    );

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            cnt        <= '0;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            null_pend  <= 1'b0;
            rd_q       <= 1'b0;
            wb_addr_q  <= '0;
            rd_addr_q  <= '0;
            wb_data_q  <= '0;
        end else begin
            resp_valid <= null_pend;
            null_pend  <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        rd_q      <= req_rd;
                        wb_addr_q <= wb_addr[AW-1:0];
                        rd_addr_q <= rd_addr[AW-1:0];
                        wb_data_q <= wb_data;
                        cnt       <= CNT_LOAD;
                        if (req_wb) begin
                            state     <= WB;
                            req_ready <= 1'b0;
                        end else if (req_rd) begin
                            state     <= RD;
                            req_ready <= 1'b0;
                        end else begin
                            null_pend <= 1'b1;
                        end
                    end
                end
                WB: begin
                    if (cnt == '0) begin
                        if (rd_q) begin
                            state <= RD;
                            cnt   <= CNT_LOAD;
                        end else begin
                            state      <= IDLE;
                            req_ready  <= 1'b1;
                            resp_valid <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                RD: begin
                    if (cnt == '0) begin
                        state      <= IDLE;
                        req_ready  <= 1'b1;
                        resp_valid <= 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                end
            endcase
        end
    end

`ifdef MAIN_MEM_STATS_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_count <= '0;
            wr_count <= '0;
        end else begin
            if (re) rd_count <= rd_count + 32'd1;
            if (we) wr_count <= wr_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_main_mem_responder.sv
// Self-checking bench for main_mem_responder: vector table plus scoreboard of expected responses.
module tb_main_mem_responder;

    localparam int LAT = 4;

    typedef struct {
        logic        wb;
        logic        rd;
        logic [31:0] wb_addr;
        logic [31:0] wb_data;
        logic [31:0] rd_addr;
        logic [31:0] exp_rdata;
        int          lat;
    } vec_t;

    typedef struct {
        int          due;
        logic        has_rd;
        logic [31:0] rdata;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_wb;
    logic        req_rd;
    logic [31:0] wb_addr;
    logic [31:0] wb_data;
    logic [31:0] rd_addr;
    logic        resp_valid;
    logic [31:0] resp_rdata;
`ifdef MAIN_MEM_STATS_EN
    logic [31:0] rd_count;
    logic [31:0] wr_count;
`endif

    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    int   exp_rd = 0;
    int   exp_wr = 0;
    exp_t sb[$];
    exp_t mon_e;
    vec_t vecs[9];
    vec_t v;
    vec_t v2;

    main_mem_responder #(.DEPTH_WORDS(1024), .LATENCY(LAT)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_wb     (req_wb),
        .req_rd     (req_rd),
        .wb_addr    (wb_addr),
        .wb_data    (wb_data),
        .rd_addr    (rd_addr),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata)
`ifdef MAIN_MEM_STATS_EN
        ,
        .rd_count   (rd_count),
        .wr_count   (wr_count)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic vec_t mk(input logic wb, input logic rd, input logic [31:0] wa,
                                input logic [31:0] wd, input logic [31:0] ra,
                                input logic [31:0] er, input int lat);
        vec_t r;
        r.wb = wb; r.rd = rd; r.wb_addr = wa; r.wb_data = wd;
        r.rd_addr = ra; r.exp_rdata = er; r.lat = lat;
        return r;
    endfunction

    task automatic drive(input vec_t x);
        req_wb  = x.wb;
        req_rd  = x.rd;
        wb_addr = x.wb_addr;
        wb_data = x.wb_data;
        rd_addr = x.rd_addr;
    endtask

    // Called at a negedge where req_ready is high: acceptance is the next posedge.
    task automatic push(input vec_t x);
        exp_t e;
        e.due    = cyc + 1 + x.lat;
        e.has_rd = x.rd;
        e.rdata  = x.exp_rdata;
        sb.push_back(e);
        if (x.rd) exp_rd++;
        if (x.wb) exp_wr++;
    endtask

    task automatic send(input vec_t x);
        drive(x);
        req_valid = 1'b1;
        for (int t = 0; t < 50 && !req_ready; t++) @(negedge clk);
        if (!req_ready) check("send_ready_timeout", 32'(req_ready), 32'd1);
        else push(x);
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        for (int t = 0; t < 100 && sb.size() != 0; t++) @(negedge clk);
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
    endtask

    always @(negedge clk) begin
        if (reset && resp_valid) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL spurious_resp: resp_valid=1 at cycle %0d, expected no response", cyc);
            end else begin
                mon_e = sb.pop_front();
                check("resp_cycle", 32'(cyc), 32'(mon_e.due));
                check("resp_ready", 32'(req_ready), 32'd1);
                if (mon_e.has_rd) check("resp_rdata", resp_rdata, mon_e.rdata);
            end
        end else if (sb.size() != 0 && cyc > sb[0].due) begin
            mon_e = sb.pop_front();
            check("resp_missing_cycle", 32'(cyc), 32'(mon_e.due));
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; req_valid = 1'b0; req_wb = 1'b0; req_rd = 1'b0;
        wb_addr = '0; wb_data = '0; rd_addr = '0;

        vecs[0] = mk(1, 0, 32'h10,  32'hDEADBEEF, 32'h0,        32'h0,        LAT);
        vecs[1] = mk(0, 1, 32'h0,   32'h0,        32'h10,       32'hDEADBEEF, LAT);
        vecs[2] = mk(1, 1, 32'h20,  32'h12345678, 32'h20,       32'h12345678, 2*LAT);
        vecs[3] = mk(1, 0, 32'h400, 32'hA5A5A5A5, 32'h0,        32'h0,        LAT);
        vecs[4] = mk(0, 1, 32'h0,   32'h0,        32'h000,      32'hA5A5A5A5, LAT);
        vecs[5] = mk(0, 0, 32'h0,   32'h0,        32'h0,        32'h0,        1);
        vecs[6] = mk(1, 1, 32'h30,  32'h0BADF00D, 32'h10,       32'hDEADBEEF, 2*LAT);
        vecs[7] = mk(0, 1, 32'h0,   32'h0,        32'h30,       32'h0BADF00D, LAT);
        vecs[8] = mk(1, 1, 32'h7FF, 32'h11111111, 32'hFFFFF3FF, 32'h11111111, 2*LAT);

        // Reset state, during and after reset.
        repeat (2) @(negedge clk);
        check("rst_ready", 32'(req_ready), 32'd1);
        check("rst_valid", 32'(resp_valid), 32'd0);
        check("rst_rdata", resp_rdata, 32'd0);
        reset = 1'b1;
        @(negedge clk);
        check("post_rst_ready", 32'(req_ready), 32'd1);
        check("post_rst_valid", 32'(resp_valid), 32'd0);

        foreach (vecs[i]) begin
            send(vecs[i]);
            wait_idle();
        end

        // Requests offered while busy are ignored.
        v = mk(0, 1, 32'h0, 32'h0, 32'h10, 32'hDEADBEEF, LAT);
        check("idle_ready", 32'(req_ready), 32'd1);
        drive(v);
        req_valid = 1'b1;
        push(v);
        @(negedge clk);
        check("busy_not_ready", 32'(req_ready), 32'd0);
        drive(mk(1, 1, 32'h10, 32'hBAD0BAD0, 32'h20, 32'h0, LAT));
        repeat (2) @(negedge clk);
        req_valid = 1'b0;
        wait_idle();
        send(mk(0, 1, 32'h0, 32'h0, 32'h10, 32'hDEADBEEF, LAT));
        wait_idle();

        // Back-to-back: second request held through the first response.
        v  = mk(0, 1, 32'h0, 32'h0, 32'h20,  32'h12345678, LAT);
        v2 = mk(0, 1, 32'h0, 32'h0, 32'h000, 32'hA5A5A5A5, LAT);
        drive(v);
        req_valid = 1'b1;
        push(v);
        @(negedge clk);
        drive(v2);
        for (int t = 0; t < 20 && !req_ready; t++) @(negedge clk);
        check("b2b_accept_in_resp_cycle", 32'(resp_valid), 32'd1);
        push(v2);
        @(negedge clk);
        req_valid = 1'b0;
        wait_idle();

        // Reset two cycles into a writeback phase aborts the write.
        send(mk(1, 0, 32'h50, 32'h01010101, 32'h0, 32'h0, LAT));
        wait_idle();
        drive(mk(1, 0, 32'h50, 32'hCAFEF00D, 32'h0, 32'h0, LAT));
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        check("abort_ready", 32'(req_ready), 32'd1);
        check("abort_valid", 32'(resp_valid), 32'd0);
        @(negedge clk);
        check("abort_ready_hold", 32'(req_ready), 32'd1);
        reset  = 1'b1;
        exp_rd = 0;
        exp_wr = 0;
        repeat (6) @(negedge clk);
        check("post_abort_valid", 32'(resp_valid), 32'd0);

        // Three reads, two writes, one null since reset.
        send(mk(0, 1, 32'h0,  32'h0,        32'h50, 32'h01010101, LAT));
        wait_idle();
        send(mk(1, 0, 32'h60, 32'h66666666, 32'h0,  32'h0,        LAT));
        wait_idle();
        send(mk(0, 0, 32'h0,  32'h0,        32'h0,  32'h0,        1));
        wait_idle();
        send(mk(1, 1, 32'h70, 32'h77777777, 32'h60, 32'h66666666, 2*LAT));
        wait_idle();
        send(mk(0, 1, 32'h0,  32'h0,        32'h70, 32'h77777777, LAT));
        wait_idle();
`ifdef MAIN_MEM_STATS_EN
        check("rd_count", rd_count, 32'(exp_rd));
        check("wr_count", wr_count, 32'(exp_wr));
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/main_mem_responder.md
# main_mem_responder

Main-memory responder serving the data cache's miss traffic: accepts one transaction at a time carrying an optional dirty-line writeback and an optional refill read, models a fixed access latency per phase, and returns refill data with a single-cycle completion pulse. Sits between the 2-way data cache's miss/writeback port and the word-addressed backing store; it is the memory end of the cache's `miss`/`memwr`/`datamemout`/`datamemin` exchange.

## Interface
- `DEPTH_WORDS`, 1024: backing-store size in 32-bit words; power of two.
- `LATENCY`, 4: cycles per memory phase (writeback or read); legal range 1..15.
- `clk` in 1: single clock, all logic on rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `req_valid` in 1: transaction offered.
- `req_ready` out 1: high only in IDLE; transfer occurs when `req_valid && req_ready` at a rising edge.
- `req_wb` in 1: transaction includes a writeback phase.
- `req_rd` in 1: transaction includes a refill read phase.
- `wb_addr` in 32: word address of the evicted line.
- `wb_data` in 32: evicted line data; full-word write.
- `rd_addr` in 32: word address to refill.
- `resp_valid` out 1: one-cycle completion pulse.
- `resp_rdata` out 32: refill data; meaningful only with `resp_valid` when the transaction had `req_rd`.

## Operation
- All request fields are captured into internal registers on acceptance; inputs may change afterwards.
- Addresses index storage with bits [log2(DEPTH_WORDS)-1:0]; upper bits ignored (wrap modulo depth).
- FSM states: IDLE, WB, RD, RESP-free design (response driven from the final phase edge).
- IDLE: on acceptance, go to WB if `req_wb`, else RD if `req_rd`, else stay IDLE and pulse `resp_valid` at the next edge (null transaction, no storage access).
- WB: load down-counter with LATENCY-1 on entry; decrement each cycle; at the edge where counter is 0, commit `wb_data` to `wb_addr`, go to RD if captured `req_rd`, else IDLE with `resp_valid` set.
- RD: same counter rule; at the edge where counter is 0, register storage word at `rd_addr` into `resp_rdata`, set `resp_valid`, go to IDLE.
- Writeback always precedes read: if `wb_addr == rd_addr` the read returns `wb_data`.
- `resp_valid` clears at the following edge unconditionally; `resp_rdata` holds until next read completion.
- Storage contents are not reset; words never written read as undefined.

## Timing
- Reset values: `req_ready`=1 (IDLE), `resp_valid`=0, `resp_rdata`=0, counter 0.
- Acceptance at edge N: read-only -> `resp_valid` high after edge N+LATENCY; writeback-only -> write committed and `resp_valid` high after edge N+LATENCY; both -> write at N+LATENCY, `resp_valid` after N+2·LATENCY; null -> after N+1.
- `req_ready` returns high in the same cycle `resp_valid` is high; a new request may be accepted in that cycle (back-to-back, no bubble).
- Reset asserted mid-transaction: FSM to IDLE immediately, pending write not committed unless its commit edge already occurred, no `resp_valid`.
- `req_valid` while not ready: ignored, not queued.

## Configuration
- `MAIN_MEM_STATS_EN` defined: adds outputs `rd_count` (32) and `wr_count` (32), incremented on each read completion and each write commit, wrapping at 2^32, reset to 0.
- Undefined: ports and counters absent; behaviour otherwise identical.

## Structure
- Package `main_mem_pkg`: FSM state enum (IDLE, WB, RD), `MAIN_MEM_MAX_LATENCY`=15, counter width constant (4).
- Sub-module `main_mem_array`: single-port word RAM, synchronous write, synchronous registered read, parameterised by `DEPTH_WORDS`.

## Test plan
- Reset, then read-only to 0x10 after writeback-only of 0xDEADBEEF to 0x10 (LATENCY=4) -> write committed at acceptance+4, read `resp_valid` exactly 4 cycles after its acceptance with `resp_rdata`=0xDEADBEEF.
- Combined wb 0x20←0x12345678 and rd 0x20 -> `resp_rdata`=0x12345678, `resp_valid` at acceptance+8.
- Address wrap: write 0xA5A5A5A5 to 0x400 (DEPTH 1024), read 0x000 -> 0xA5A5A5A5.
- Back-to-back: second `req_valid` held high through first response -> accepted in `resp_valid` cycle, second response exactly LATENCY cycles later; `req_valid` during busy ignored.
- Reset asserted 2 cycles into a writeback phase -> `req_ready`=1, `resp_valid`=0, later read of that address does not return the aborted data.
- With `MAIN_MEM_STATS_EN`: 3 reads, 2 writes, 1 null -> `rd_count`=3, `wr_count`=2.
